// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-format defaults and the transmitter state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// The DBIT/SB_TICK/OVS defaults are shared with the receiver so both ends of a
// link agree on the frame format unless a parent overrides them explicitly.
package uart_pkg;

  // Default frame format: 8 data bits, 1 stop bit, 16x oversampling.
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OVS_DEF     = 16;

  // Transmitter FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Larger of two ints; sizes the oversample counter so it covers both the
  // per-bit period and the (possibly longer) stop period.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter draining a first-word-fall-through TX FIFO onto the serial pin.
// Latency: pop and start bit one CLK after fifo_empty falls; frame is OVS*(1+DBIT)+SB_TICK baud ticks.
// Backpressure: pops only from IDLE, so the FIFO is held off for the whole frame; fifo_empty is ignored mid-frame.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET_N      asynchronous active-low reset; abandons any frame in flight
//   s_tick       one-CLK baud pulse at OVS x bit rate (ignored in IDLE)
//   fifo_empty   TX FIFO empty flag
//   fifo_r_data  FIFO head word, valid while !fifo_empty; bits above DBIT ignored
//   fifo_rd      registered one-CLK pop strobe (first CLK of START only)
//   tx           registered serial line, idle high
//   tx_busy      high whenever the FSM is not in IDLE
//   tx_done_tick registered one-CLK pulse at the end of the stop period
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int OVS     = OVS_DEF
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       s_tick,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_r_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  // Oversample counter spans the longer of a bit period and the stop period.
  localparam int SCW = $clog2(max2(OVS, SB_TICK));
  localparam int NCW = $clog2(DBIT);

  localparam logic [SCW-1:0] OVS_LAST  = SCW'(OVS - 1);
  localparam logic [SCW-1:0] STOP_LAST = SCW'(SB_TICK - 1);
  localparam logic [NCW-1:0] DBIT_LAST = NCW'(DBIT - 1);

  uart_state_e     state_q, state_d;
  logic [SCW-1:0]  s_cnt_q, s_cnt_d;
  logic [NCW-1:0]  n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q,     b_d;
  logic            tx_q,    tx_d;
  logic            rd_q,    rd_d;
  logic            done_q,  done_d;

  // ---------------------------------------------------------------------------
  // State register. tx resets high so the line reads idle immediately on an
  // asynchronous reset, even mid-frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. tx_d is the level the line takes after this edge, so the
  // pin changes on the same edge as the state it belongs to and never glitches.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // Latch the FWFT head and pop in the same step; a baud tick on this
        // edge is deliberately dropped by clearing s_cnt.
        if (!fifo_empty) begin
          b_d     = fifo_r_data[DBIT-1:0];
          rd_d    = 1'b1;
          tx_d    = 1'b0;
          s_cnt_d = '0;
          n_cnt_d = '0;
          state_d = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_cnt_q == OVS_LAST) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            tx_d    = b_q[0];
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == OVS_LAST) begin
            b_d     = b_q >> 1;
            s_cnt_d = '0;
            if (n_cnt_q == DBIT_LAST) begin
              n_cnt_d = '0;
              tx_d    = 1'b1;
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
              // b_q[1] is the bit that becomes b_q[0] after this shift.
              tx_d    = b_q[1];
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            s_cnt_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign fifo_rd      = rd_q;
  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo_reader;

  logic       CLK         = 1'b0;
  logic       RESET_N     = 1'b0;
  logic       s_tick      = 1'b0;
  logic       fifo_empty  = 1'b1;
  logic [7:0] fifo_r_data = 8'h00;
  logic       fifo_rd, tx, tx_busy, tx_done_tick;

  // Second instance: 2 stop bits, s_tick tied high.
  logic       b_empty = 1'b1;
  logic [7:0] b_data  = 8'hFF;
  logic       b_rd, b_tx, b_busy, b_done;

  always #5 CLK = ~CLK;

  uart_tx_fifo_reader dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .s_tick       (s_tick),
    .fifo_empty   (fifo_empty),
    .fifo_r_data  (fifo_r_data),
    .fifo_rd      (fifo_rd),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(32), .OVS(16)) dut_b (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .s_tick       (1'b1),
    .fifo_empty   (b_empty),
    .fifo_r_data  (b_data),
    .fifo_rd      (b_rd),
    .tx           (b_tx),
    .tx_busy      (b_busy),
    .tx_done_tick (b_done)
  );

  // Baud tick: one CLK high every 16 CLK, changed on the falling edge.
  int tick_div = 0;
  always @(negedge CLK) begin
    if (tick_div == 15) begin
      tick_div = 0;
      s_tick   = 1'b1;
    end else begin
      tick_div = tick_div + 1;
      s_tick   = 1'b0;
    end
  end

  // FWFT FIFO model. The main thread appends to push_buf; this process alone
  // owns the queue and the flag/data it presents to the DUT.
  logic [7:0] push_buf [0:63];
  int         push_wr  = 0;
  int         push_rd  = 0;
  logic [7:0] fq[$];
  int         pop_cnt  = 0;
  int         done_cnt = 0;

  always @(negedge CLK) begin
    if (fifo_rd === 1'b1) begin
      pop_cnt++;
      if (fq.size() > 0) fq.delete(0);
    end
    while (push_rd < push_wr) begin
      fq.push_back(push_buf[push_rd]);
      push_rd++;
    end
    fifo_empty  = (fq.size() == 0);
    fifo_r_data = (fq.size() == 0) ? 8'h00 : fq[0];
    if (tx_done_tick === 1'b1) done_cnt++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    push_buf[push_wr] = d;
    push_wr++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Waits for the pop strobe, then records the tx level at the start of each
  // 16-tick window (bits[0] = start bit ... bits[9] = stop bit) until
  // tx_done_tick. gap = CLKs spent waiting for the pop; glitch = tx moved
  // inside a window; nticks = baud ticks from pop to done.
  task automatic capture_frame(output logic [9:0] bits, output int nticks, output int gap,
                               output bit glitch, output bit tmo);
    int   k;
    int   cyc;
    logic tk;
    bits = '0; nticks = 0; gap = 0; glitch = 0; tmo = 0; k = 0; cyc = 0;
    while (fifo_rd !== 1'b1) begin
      if (gap >= 100) begin
        tmo = 1;
        return;
      end
      step();
      gap++;
    end
    bits[0] = tx;
    while (1) begin
      @(posedge CLK);
      tk = s_tick;
      #1;
      cyc++;
      if (tk) k++;
      if (tx_done_tick === 1'b1) begin
        nticks = k;
        return;
      end
      if (cyc > 3000) begin
        tmo = 1;
        nticks = k;
        return;
      end
      if (k < 160) begin
        if (tk && (k % 16 == 0)) bits[k/16] = tx;
        else if (tx !== bits[k/16]) glitch = 1;
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;      // byte pushed into the FIFO
    logic [9:0] exp_bits;  // line levels {stop, d7..d0, start}
  } vec_t;

  initial begin
    vec_t       tbl [6];
    logic [9:0] bits;
    int         nt, gap, viol, p0, d0, k, c, lowc, extra;
    bit         gl, tmo;
    logic       tk, busy_175;

    tbl[0] = '{8'h00, 10'h200};
    tbl[1] = '{8'hFF, 10'h3FE};
    tbl[2] = '{8'hA5, 10'h34A};
    tbl[3] = '{8'h3C, 10'h278};
    tbl[4] = '{8'h80, 10'h300};
    tbl[5] = '{8'h01, 10'h202};

    // 1. Reset held with a byte waiting in the FIFO.
    push(8'h55);
    viol = 0;
    repeat (20) begin
      step();
      if (tx !== 1'b1 || fifo_rd !== 1'b0 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0) viol++;
      if (b_tx !== 1'b1 || b_rd !== 1'b0 || b_busy !== 1'b0) viol++;
    end
    check("reset_hold_outputs", 32'(viol), 32'd0);
    check("reset_no_pop", 32'(pop_cnt), 32'd0);
    check("reset_fifo_kept", 32'(fifo_empty), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // 2. Single byte 0x55.
    capture_frame(bits, nt, gap, gl, tmo);
    check("b55_timeout", 32'(tmo), 32'd0);
    check("b55_levels", 32'(bits), 32'h2AA);
    check("b55_ticks", 32'(nt), 32'd160);
    check("b55_glitch", 32'(gl), 32'd0);
    check("b55_tx_at_done", 32'(tx), 32'd1);
    repeat (3) step();
    check("b55_pops", 32'(pop_cnt), 32'd1);
    check("b55_done_pulses", 32'(done_cnt), 32'd1);
    check("b55_idle", 32'(tx_busy), 32'd0);

    // Table of single frames.
    for (int i = 0; i < 6; i++) begin
      p0 = pop_cnt;
      d0 = done_cnt;
      push(tbl[i].data);
      capture_frame(bits, nt, gap, gl, tmo);
      check($sformatf("vec%0d_timeout", i), 32'(tmo), 32'd0);
      check($sformatf("vec%0d_levels", i), 32'(bits), 32'(tbl[i].exp_bits));
      check($sformatf("vec%0d_ticks", i), 32'(nt), 32'd160);
      check($sformatf("vec%0d_glitch", i), 32'(gl), 32'd0);
      repeat (3) step();
      check($sformatf("vec%0d_pops", i), 32'(pop_cnt - p0), 32'd1);
      check($sformatf("vec%0d_done", i), 32'(done_cnt - d0), 32'd1);
    end

    // 3. Back-to-back frames from a preloaded FIFO.
    p0 = pop_cnt;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    for (int i = 0; i < 3; i++) begin
      capture_frame(bits, nt, gap, gl, tmo);
      check($sformatf("b2b%0d_timeout", i), 32'(tmo), 32'd0);
      check($sformatf("b2b%0d_levels", i), 32'(bits), 32'h202 + 32'(2 * i));
      check($sformatf("b2b%0d_ticks", i), 32'(nt), 32'd160);
      if (i > 0) check($sformatf("b2b%0d_gap", i), 32'(gap), 32'd1);
    end
    repeat (3) step();
    check("b2b_pops", 32'(pop_cnt - p0), 32'd3);
    check("b2b_tx_idle", 32'(tx), 32'd1);
    check("b2b_busy_idle", 32'(tx_busy), 32'd0);
    check("b2b_fifo_drained", 32'(fifo_empty), 32'd1);

    // 4. Empty FIFO for 1000 CLK.
    p0 = pop_cnt;
    viol = 0;
    repeat (1000) begin
      step();
      if (tx !== 1'b1 || fifo_rd !== 1'b0 || tx_busy !== 1'b0) viol++;
    end
    check("empty_idle_outputs", 32'(viol), 32'd0);
    check("empty_no_pop", 32'(pop_cnt - p0), 32'd0);

    // 5. Reset in the middle of data bit 3 of 0xA5; 0x3C follows.
    p0 = pop_cnt;
    d0 = done_cnt;
    push(8'hA5);
    push(8'h3C);
    c = 0;
    while (fifo_rd !== 1'b1 && c < 100) begin
      step();
      c++;
    end
    check("rst_mid_pop_seen", 32'(fifo_rd), 32'd1);
    k = 0;
    c = 0;
    while (k < 72 && c < 2000) begin
      @(posedge CLK);
      tk = s_tick;
      #1;
      c++;
      if (tk) k++;
    end
    check("rst_mid_bit3_level", 32'(tx), 32'd0);
    check("rst_mid_busy", 32'(tx_busy), 32'd1);
    #1;
    RESET_N = 1'b0;
    #1;
    check("rst_mid_tx_async", 32'(tx), 32'd1);
    check("rst_mid_busy_async", 32'(tx_busy), 32'd0);
    check("rst_mid_rd_async", 32'(fifo_rd), 32'd0);
    repeat (3) step();
    @(negedge CLK);
    RESET_N = 1'b1;
    capture_frame(bits, nt, gap, gl, tmo);
    check("rst_next_timeout", 32'(tmo), 32'd0);
    check("rst_next_levels", 32'(bits), 32'h278);
    check("rst_next_ticks", 32'(nt), 32'd160);
    check("rst_next_glitch", 32'(gl), 32'd0);
    repeat (3) step();
    check("rst_pops", 32'(pop_cnt - p0), 32'd2);
    check("rst_done", 32'(done_cnt - d0), 32'd1);
    check("rst_fifo_drained", 32'(fifo_empty), 32'd1);

    // 6. s_tick tied high, SB_TICK=32, byte 0xFF.
    b_empty = 1'b0;
    c = 0;
    while (b_rd !== 1'b1 && c < 10) begin
      step();
      c++;
    end
    check("fast_pop_seen", 32'(b_rd), 32'd1);
    b_empty  = 1'b1;
    lowc     = (b_tx === 1'b0) ? 1 : 0;
    extra    = 0;
    busy_175 = 1'b0;
    c        = 0;
    while (c < 400) begin
      step();
      c++;
      if (b_done === 1'b1) break;
      if (b_tx === 1'b0) lowc++;
      if (b_rd === 1'b1) extra++;
      if (c == 175) busy_175 = b_busy;
    end
    check("fast_frame_clks", 32'(c), 32'd176);
    check("fast_start_low_clks", 32'(lowc), 32'd16);
    check("fast_extra_pops", 32'(extra), 32'd0);
    check("fast_busy_before_done", 32'(busy_175), 32'd1);
    check("fast_tx_at_done", 32'(b_tx), 32'd1);
    check("fast_busy_at_done", 32'(b_busy), 32'd0);
    viol = 0;
    repeat (5) begin
      step();
      if (b_rd !== 1'b0 || b_busy !== 1'b0 || b_tx !== 1'b1 || b_done !== 1'b0) viol++;
    end
    check("fast_idle_after", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
